// File: rtl/rv32_decode_pkg.sv
// Shared types and opcode constants for the RV32I decode stage.
// An illegal instruction carries no class: wb_sel, imm_type and all enables read 0.
package rv32_decode_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        WB_ALU    = 3'd0,
        WB_LOAD   = 3'd1,
        WB_IMM    = 3'd2,
        WB_IADDER = 3'd3,
        WB_PC4    = 3'd4
    } wb_sel_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_opcode;
        wb_sel_t     wb_sel;
        imm_type_t   imm_type;
        logic        mem_wr_req;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic        alu_src;
        logic        iadder_src;
        logic        wr_en;
        logic        muldiv;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/rv32_decode_if.sv
// Upstream/downstream handshake bundle of the decode stage.
interface rv32_decode_if #(parameter int CNT_W = 16);
    logic [31:0]      instr_in;
    logic [31:0]      pc_in;
    logic             valid_in;
    logic             ready_out;
    logic             flush_in;
    logic             valid_out;
    logic             ready_in;
    logic [31:0]      pc_out;
    logic [4:0]       rd_addr_out;
    logic [4:0]       rs1_addr_out;
    logic [4:0]       rs2_addr_out;
    logic [3:0]       alu_opcode_out;
    logic [2:0]       wb_mux_sel_out;
    logic [2:0]       imm_type_out;
    logic             mem_wr_req_out;
    logic [1:0]       load_size_out;
    logic             load_unsigned_out;
    logic             alu_src_out;
    logic             iadder_src_out;
    logic             wr_en_out;
    logic             muldiv_out;
    logic             illegal_out;
    logic [CNT_W-1:0] illegal_cnt_out;

    modport master (
        output instr_in, pc_in, valid_in, flush_in, ready_in,
        input  ready_out, valid_out, pc_out, rd_addr_out, rs1_addr_out, rs2_addr_out,
               alu_opcode_out, wb_mux_sel_out, imm_type_out, mem_wr_req_out, load_size_out,
               load_unsigned_out, alu_src_out, iadder_src_out, wr_en_out, muldiv_out,
               illegal_out, illegal_cnt_out
    );

    modport slave (
        input  instr_in, pc_in, valid_in, flush_in, ready_in,
        output ready_out, valid_out, pc_out, rd_addr_out, rs1_addr_out, rs2_addr_out,
               alu_opcode_out, wb_mux_sel_out, imm_type_out, mem_wr_req_out, load_size_out,
               load_unsigned_out, alu_src_out, iadder_src_out, wr_en_out, muldiv_out,
               illegal_out, illegal_cnt_out
    );
endinterface

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I(+M) instruction decoder producing one FIFO payload.
module rv32_decode_comb
    import rv32_decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output decode_t     dec_o
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic std, is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op;
    logic op_ok, opimm_ok, legal;

    assign opc = instr_i[6:2];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign std = (instr_i[1:0] == 2'b11);

    assign is_lui   = std && (opc == OPC_LUI);
    assign is_auipc = std && (opc == OPC_AUIPC);
    assign is_jal   = std && (opc == OPC_JAL);
    assign is_jalr  = std && (opc == OPC_JALR);
    assign is_br    = std && (opc == OPC_BRANCH);
    assign is_load  = std && (opc == OPC_LOAD);
    assign is_store = std && (opc == OPC_STORE);
    assign is_opimm = std && (opc == OPC_OP_IMM);
    assign is_op    = std && (opc == OPC_OP);

    // funct7 0100000 is only meaningful for SUB and SRA
    assign op_ok = (f7 == 7'b0000000)
                || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))
                || (ENABLE_M && (f7 == 7'b0000001));
    assign opimm_ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                      (f3 == 3'b101) ? ((f7 == 7'b0000000) || (f7 == 7'b0100000)) : 1'b1;

    assign legal = is_lui || is_auipc || is_jal
                || (is_jalr && (f3 == 3'b000))
                || (is_br && (f3[2:1] != 2'b01))
                || (is_load && !((f3 == 3'b011) || (f3[2:1] == 2'b11)))
                || (is_store && (f3 <= 3'b010))
                || (is_opimm && opimm_ok)
                || (is_op && op_ok);

    always_comb begin
        dec_o               = '0;
        dec_o.pc            = pc_i;
        dec_o.rd            = instr_i[11:7];
        dec_o.rs1           = instr_i[19:15];
        dec_o.rs2           = instr_i[24:20];
        dec_o.alu_opcode    = {(is_op || (is_opimm && (f3 == 3'b101))) && instr_i[30], f3};
        dec_o.load_size     = f3[1:0];
        dec_o.load_unsigned = f3[2];
        dec_o.alu_src       = instr_i[5];
        dec_o.illegal       = !legal;
        if (legal) begin
            if (is_load)              dec_o.wb_sel = WB_LOAD;
            else if (is_lui)          dec_o.wb_sel = WB_IMM;
            else if (is_auipc)        dec_o.wb_sel = WB_IADDER;
            else if (is_jal || is_jalr) dec_o.wb_sel = WB_PC4;

            if (is_opimm || is_load || is_jalr) dec_o.imm_type = IMM_I;
            else if (is_store)                  dec_o.imm_type = IMM_S;
            else if (is_br)                     dec_o.imm_type = IMM_B;
            else if (is_lui || is_auipc)        dec_o.imm_type = IMM_U;
            else if (is_jal)                    dec_o.imm_type = IMM_J;

            dec_o.mem_wr_req = is_store;
            dec_o.iadder_src = is_load || is_store || is_jalr;
            dec_o.wr_en      = is_lui || is_auipc || is_jal || is_jalr || is_op || is_opimm || is_load;
            dec_o.muldiv     = is_op && (f7 == 7'b0000001);
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: combinational decode into a small output FIFO with flush
// support and a saturating illegal-instruction counter.
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input logic          clk_in,
    input logic          reset_in,
    rv32_decode_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    decode_t          mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CNT_W-1:0] ill_cnt_q;
    decode_t          dec_d, head;
    logic             full, empty, push, pop;

    rv32_decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
        .instr_i (bus.instr_in),
        .pc_i    (bus.pc_in),
        .dec_o   (dec_d)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.valid_in && !full && !bus.flush_in;
    assign pop   = !empty && bus.ready_in && !bus.flush_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else if (bus.flush_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (push && dec_d.illegal && !(&ill_cnt_q)) ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    // Payload storage carries no reset; an empty FIFO masks the head to zero.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= dec_d;
    end

    assign head = empty ? decode_t'('0) : mem_q[rd_ptr_q];

    assign bus.ready_out         = !full;
    assign bus.valid_out         = !empty;
    assign bus.pc_out            = head.pc;
    assign bus.rd_addr_out       = head.rd;
    assign bus.rs1_addr_out      = head.rs1;
    assign bus.rs2_addr_out      = head.rs2;
    assign bus.alu_opcode_out    = head.alu_opcode;
    assign bus.wb_mux_sel_out    = head.wb_sel;
    assign bus.imm_type_out      = head.imm_type;
    assign bus.mem_wr_req_out    = head.mem_wr_req;
    assign bus.load_size_out     = head.load_size;
    assign bus.load_unsigned_out = head.load_unsigned;
    assign bus.alu_src_out       = head.alu_src;
    assign bus.iadder_src_out    = head.iadder_src;
    assign bus.wr_en_out         = head.wr_en;
    assign bus.muldiv_out        = head.muldiv;
    assign bus.illegal_out       = head.illegal;
    assign bus.illegal_cnt_out   = ill_cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: two instances (DEPTH=2/no M/8-bit counter and
// DEPTH=4/M/16-bit counter) driven by the same stimulus.
module tb_rv32_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu;
        logic [2:0]  wb;
        logic [2:0]  imm;
        logic        mw;
        logic [1:0]  lsz;
        logic        lu;
        logic        asrc;
        logic        isrc;
        logic        wr;
        logic        md;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic        rdy = 1'b0;
    logic        fl  = 1'b0;
    logic [31:0] ins = '0;
    logic [31:0] pc  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_decode_if #(.CNT_W(8))  ifa ();
    rv32_decode_if #(.CNT_W(16)) ifb ();

    assign ifa.instr_in = ins;
    assign ifa.pc_in    = pc;
    assign ifa.valid_in = vin;
    assign ifa.ready_in = rdy;
    assign ifa.flush_in = fl;
    assign ifb.instr_in = ins;
    assign ifb.pc_in    = pc;
    assign ifb.valid_in = vin;
    assign ifb.ready_in = rdy;
    assign ifb.flush_in = fl;

    rv32_decode_stage #(.DEPTH(2), .ENABLE_M(1'b0), .CNT_W(8)) dut_a (
        .clk_in(clk), .reset_in(rst), .bus(ifa)
    );
    rv32_decode_stage #(.DEPTH(4), .ENABLE_M(1'b1), .CNT_W(16)) dut_b (
        .clk_in(clk), .reset_in(rst), .bus(ifb)
    );

    exp_t got_a, got_b;
    assign got_a = {ifa.pc_out, ifa.rd_addr_out, ifa.rs1_addr_out, ifa.rs2_addr_out,
                    ifa.alu_opcode_out, ifa.wb_mux_sel_out, ifa.imm_type_out, ifa.mem_wr_req_out,
                    ifa.load_size_out, ifa.load_unsigned_out, ifa.alu_src_out, ifa.iadder_src_out,
                    ifa.wr_en_out, ifa.muldiv_out, ifa.illegal_out};
    assign got_b = {ifb.pc_out, ifb.rd_addr_out, ifb.rs1_addr_out, ifb.rs2_addr_out,
                    ifb.alu_opcode_out, ifb.wb_mux_sel_out, ifb.imm_type_out, ifb.mem_wr_req_out,
                    ifb.load_size_out, ifb.load_unsigned_out, ifb.alu_src_out, ifb.iadder_src_out,
                    ifb.wr_en_out, ifb.muldiv_out, ifb.illegal_out};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input int rd, input int rs1, input int rs2,
                                input int alu, input int wb, input int imm, input int mw,
                                input int lsz, input int lu, input int asrc, input int isrc,
                                input int wr, input int md, input int ill);
        exp_t e;
        e = {p, 5'(rd), 5'(rs1), 5'(rs2), 4'(alu), 3'(wb), 3'(imm), 1'(mw), 2'(lsz),
             1'(lu), 1'(asrc), 1'(isrc), 1'(wr), 1'(md), 1'(ill)};
        return e;
    endfunction

    // Reference decoder written from the instruction-class rules on full 7-bit opcodes.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input bit enm);
        exp_t e;
        bit legal;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        legal = 1'b0;
        e.pc = p; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.alu = {1'b0, f3}; e.lsz = f3[1:0]; e.lu = f3[2]; e.asrc = i[5];
        case (i[6:0])
            7'h37: begin legal = 1; e.wb = 2; e.imm = 4; e.wr = 1; end
            7'h17: begin legal = 1; e.wb = 3; e.imm = 4; e.wr = 1; end
            7'h6F: begin legal = 1; e.wb = 4; e.imm = 5; e.wr = 1; end
            7'h67: begin legal = (f3 == 0); e.wb = 4; e.imm = 1; e.wr = 1; e.isrc = 1; end
            7'h63: begin legal = !(f3 == 2 || f3 == 3); e.imm = 3; end
            7'h03: begin legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                         e.wb = 1; e.imm = 1; e.wr = 1; e.isrc = 1; end
            7'h23: begin legal = (f3 <= 2); e.imm = 2; e.isrc = 1; e.mw = 1; end
            7'h13: begin
                if (f3 == 1)      legal = (f7 == 0);
                else if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
                else              legal = 1;
                if (f3 == 5) e.alu[3] = i[30];
                e.imm = 1; e.wr = 1;
            end
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (enm && f7 == 7'h01);
                e.md = enm && (f7 == 7'h01);
                e.alu[3] = i[30]; e.wr = 1;
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            e.wb = 0; e.imm = 0; e.isrc = 0; e.wr = 0; e.mw = 0; e.md = 0;
        end
        e.ill = !legal;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          sel;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        r   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel < 9) begin
            r[6:0] = ops[sel];
            if (sel >= 7) begin
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    vec_t tbl [11];
    exp_t qa [$];
    exp_t qb [$];
    int   cnta, cntb, nill_a, nill_b;
    exp_t ha, hb, da, db;
    bit   pa, poa, pb, pob;

    initial begin
        tbl[0]  = '{32'h00510093, mk(32'h1000, 1, 2, 5, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[1]  = '{32'h402081B3, mk(32'h1004, 3, 1, 2, 4'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[2]  = '{32'h40335293, mk(32'h1008, 5, 6, 3, 4'hD, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0)};
        tbl[3]  = '{32'h0020A423, mk(32'h100C, 8, 1, 2, 4'h2, 0, 2, 1, 2, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{32'h022081B3, mk(32'h1010, 3, 1, 2, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1)};
        tbl[5]  = '{32'h123452B7, mk(32'h1014, 5, 8, 3, 4'h5, 2, 4, 0, 1, 1, 1, 0, 1, 0, 0)};
        tbl[6]  = '{32'h008000EF, mk(32'h1018, 1, 0, 8, 4'h0, 4, 5, 0, 0, 0, 1, 0, 1, 0, 0)};
        tbl[7]  = '{32'h0040A103, mk(32'h101C, 2, 1, 4, 4'h2, 1, 1, 0, 2, 0, 0, 1, 1, 0, 0)};
        tbl[8]  = '{32'h00000000, mk(32'h1020, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[9]  = '{32'h00208463, mk(32'h1024, 8, 1, 2, 4'h0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0)};
        tbl[10] = '{32'h000080E7, mk(32'h1028, 1, 1, 0, 4'h0, 4, 1, 0, 0, 0, 1, 1, 1, 0, 0)};

        // Reset state
        rst = 1; step(); step();
        chk("rst_ready_a", ifa.ready_out, 1);
        chk("rst_valid_a", ifa.valid_out, 0);
        chk("rst_data_a", got_a, 0);
        chk("rst_cnt_a", ifa.illegal_cnt_out, 0);
        chk("rst_ready_b", ifb.ready_out, 1);
        chk("rst_valid_b", ifb.valid_out, 0);
        rst = 0;

        // Decode table: one instruction per cycle, drained immediately
        nill_a = 0; nill_b = 0;
        rdy = 1;
        foreach (tbl[k]) begin
            ins = tbl[k].instr; pc = tbl[k].exp.pc; vin = 1;
            step();
            vin = 0;
            chk($sformatf("tbl%0d_valid", k), ifa.valid_out, 1);
            chk($sformatf("tbl%0d_dec_a", k), got_a, tbl[k].exp);
            nill_a += int'(tbl[k].exp.ill);
            if (tbl[k].instr == 32'h022081B3) begin
                chk("mul_m_muldiv", got_b.md, 1);
                chk("mul_m_illegal", got_b.ill, 0);
                chk("mul_m_wr_en", got_b.wr, 1);
            end else begin
                chk($sformatf("tbl%0d_dec_b", k), got_b, tbl[k].exp);
                nill_b += int'(tbl[k].exp.ill);
            end
        end
        step();
        chk("tbl_drained", ifa.valid_out, 0);
        chk("tbl_cnt_a", ifa.illegal_cnt_out, nill_a);
        chk("tbl_cnt_b", ifb.illegal_cnt_out, nill_b);

        // Backpressure on the DEPTH=2 instance
        rst = 1; step(); rst = 0;
        rdy = 0; vin = 1; ins = 32'h00510093;
        pc = 32'h100; step();
        chk("bp_ready_after1", ifa.ready_out, 1);
        pc = 32'h104; step();
        chk("bp_ready_full", ifa.ready_out, 0);
        chk("bp_valid_full", ifa.valid_out, 1);
        pc = 32'h108;
        repeat (3) begin
            step();
            chk("bp_hold_ready", ifa.ready_out, 0);
            chk("bp_hold_pc", ifa.pc_out, 32'h100);
        end
        rdy = 1;
        chk("bp_full_pop_ready", ifa.ready_out, 0);
        step();
        chk("bp_order_pc1", ifa.pc_out, 32'h104);
        chk("bp_ready_again", ifa.ready_out, 1);
        step();
        chk("bp_order_pc2", ifa.pc_out, 32'h108);
        vin = 0;
        step();
        chk("bp_empty", ifa.valid_out, 0);

        // Flush with two entries plus a valid illegal input
        rdy = 0; vin = 1; ins = 32'h00510093;
        pc = 32'h200; step();
        pc = 32'h204; step();
        ins = 32'h00000000; pc = 32'h208; fl = 1;
        step();
        fl = 0;
        chk("fl_valid", ifa.valid_out, 0);
        chk("fl_ready", ifa.ready_out, 1);
        chk("fl_cnt", ifa.illegal_cnt_out, 0);
        ins = 32'h00510093; pc = 32'h20C;
        step();
        chk("fl_next_valid", ifa.valid_out, 1);
        chk("fl_next_pc", ifa.pc_out, 32'h20C);
        vin = 0; rdy = 1;
        step();
        fl = 1; step(); fl = 0;
        chk("fl_empty_valid", ifa.valid_out, 0);
        chk("fl_empty_ready", ifa.ready_out, 1);

        // Counter saturation then mid-stream reset
        rst = 1; step(); rst = 0;
        ins = 32'h00000000; vin = 1; rdy = 1;
        repeat ((1 << 8) + 5) step();
        chk("sat_cnt", ifa.illegal_cnt_out, 8'hFF);
        chk("sat_illegal", ifa.illegal_out, 1);
        chk("sat_cnt_b", ifb.illegal_cnt_out, (1 << 8) + 5);
        rst = 1; step();
        chk("mrst_valid", ifa.valid_out, 0);
        chk("mrst_ready", ifa.ready_out, 1);
        chk("mrst_data", got_a, 0);
        chk("mrst_cnt", ifa.illegal_cnt_out, 0);
        rst = 0; vin = 0;

        // Randomized traffic against queue models
        rst = 1; step(); rst = 0;
        cnta = 0; cntb = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ha = '0; hb = '0;
            if (qa.size() > 0) ha = qa[0];
            if (qb.size() > 0) hb = qb[0];
            chk("rnd_ready_a", ifa.ready_out, qa.size() < 2);
            chk("rnd_valid_a", ifa.valid_out, qa.size() > 0);
            chk("rnd_head_a", got_a, ha);
            chk("rnd_cnt_a", ifa.illegal_cnt_out, cnta);
            chk("rnd_ready_b", ifb.ready_out, qb.size() < 4);
            chk("rnd_valid_b", ifb.valid_out, qb.size() > 0);
            chk("rnd_head_b", got_b, hb);
            chk("rnd_cnt_b", ifb.illegal_cnt_out, cntb);

            vin = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) == 0);
            ins = gen_instr();
            pc  = $urandom();

            if (rst) begin
                qa.delete(); qb.delete(); cnta = 0; cntb = 0;
            end else if (fl) begin
                qa.delete(); qb.delete();
            end else begin
                pa = vin && (qa.size() < 2); poa = rdy && (qa.size() > 0);
                pb = vin && (qb.size() < 4); pob = rdy && (qb.size() > 0);
                da = model(ins, pc, 1'b0);
                db = model(ins, pc, 1'b1);
                if (poa) void'(qa.pop_front());
                if (pob) void'(qb.pop_front());
                if (pa) begin
                    qa.push_back(da);
                    if (da.ill && cnta < 255) cnta++;
                end
                if (pb) begin
                    qb.push_back(db);
                    if (db.ill && cntb < 65535) cntb++;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
